contador_nivel2_timer: RTL and testbench
========================================

Name: contador_nivel2_timer

Overview:
- Three-digit BCD countdown timer (M:SS) for the microwave controller's timing datapath.
- Digits are keyed in one at a time, shifting in from the right, while `loadn` is low.
- With `loadn` high and `enable` high, the value counts down one second per clock until 0:00, then raises `timer_done` and holds.

Parameters:
- None. Digit widths are fixed at 4 bits BCD.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- clearn  input  1  reset; synchronous and active-low; clears all digits.
- data  input  4  keypad BCD digit to shift in during load mode.
- enable  input  1  count enable; active-high.
- loadn  input  1  load mode select; active-low (0 = load digits, 1 = count).
- secs  output  4  units-of-seconds BCD digit, 0..9.
- tens_secs  output  4  tens-of-seconds BCD digit.
- minutes  output  4  minutes BCD digit, 0..9.
- timer_done  output  1  high while all three digits are zero.

Behaviour:
- Priority per rising CLK edge: clearn=0 > loadn=0 > (loadn=1 & enable=1) > hold.
- Reset (clearn=0 at the edge):
  - secs, tens_secs and minutes all become 0.
  - timer_done therefore reads 1.
  - Reset is synchronous only; clearn has no effect without a rising edge.
  - Reset applied mid-load or mid-count aborts that operation.
- Load (clearn=1, loadn=0), with data in 0..9:
  - minutes <= tens_secs; tens_secs <= secs; secs <= data.
  - The previous minutes digit is discarded.
  - If data > 9, the edge is ignored and all digits hold.
  - enable is ignored in load mode.
  - Load values are accepted as-is, so tens_secs may hold 6..9 (e.g. 1:79).
- Count (clearn=1, loadn=1, enable=1, not all digits zero): decrement the M:SS value by one per edge.
  - If secs > 0: secs - 1.
  - Else if tens_secs > 0: tens_secs - 1, secs = 9.
  - Else if minutes > 0: minutes - 1, tens_secs = 5, secs = 9.
  - Total edges from a loaded value to 0:00 = minutes*60 + tens_secs*10 + secs.
- Count at 0:00: the counter holds at 0:00 and never wraps; timer_done stays 1.
- Hold: loadn=1 and enable=0 keeps all digits unchanged.
- timer_done:
  - Combinational: 1 exactly when secs = tens_secs = minutes = 0, with zero latency relative to the digits.
  - Also 1 after reset and after loading all zeros.
- Latency:
  - Load and count updates are visible on the outputs immediately after the active edge.
  - There is no pipeline.

Test Plan:
- Reset: clearn=0 for one edge -> secs=0, tens_secs=0, minutes=0, timer_done=1.
- Load sequence: loadn=0, data 2,1,7,9 on four successive edges -> after each edge secs/tens/min = 2/0/0, 1/2/0, 7/1/2, 9/7/1 (final display 1:79), timer_done=0.
- Countdown: after the load above, loadn=1, enable=1.
  - 9 edges -> 1:70.
  - 10th edge -> 1:69.
  - 79th edge -> 1:00.
  - 80th edge -> 0:59.
  - 139th edge -> 0:00, timer_done=1.
  - Further edges hold 0:00.
- Hold: mid-count set enable=0 for 10 edges -> digits unchanged; re-enable -> decrement resumes from the same value.
- Invalid key: loadn=0, data=12 -> no shift; then data=5 -> shift occurs normally.
- Reset mid-count: clearn=0 during countdown at 0:45 -> next edge 0:00, timer_done=1; a new load then works normally.

Source files
------------

// File: rtl/contador_nivel2_timer_if.sv
// Keypad/display bundle for the M:SS countdown timer.
// The master drives the keypad and mode controls; the slave (timer) drives the BCD digits and the done flag.
interface contador_nivel2_timer_if;
    logic [3:0] data;
    logic       enable;
    logic       loadn;
    logic [3:0] secs;
    logic [3:0] tens_secs;
    logic [3:0] minutes;
    logic       timer_done;

    modport master (
        output data, enable, loadn,
        input  secs, tens_secs, minutes, timer_done
    );

    modport slave (
        input  data, enable, loadn,
        output secs, tens_secs, minutes, timer_done
    );
endinterface

// File: rtl/contador_nivel2_timer.sv
// Three-digit BCD M:SS countdown timer: keypad digits shift in from the right while loadn is low,
// then the value counts down one second per enabled clock and holds at 0:00.
module contador_nivel2_timer (
    input logic                  CLK,
    input logic                  clearn,
    contador_nivel2_timer_if.slave bus
);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_COUNT
    } op_t;

    op_t        op;
    logic [3:0] secs_q, tens_q, min_q;
    logic [3:0] secs_d, tens_d, min_d;
    logic       all_zero;
    logic       key_valid;

    assign all_zero  = (secs_q == '0) && (tens_q == '0) && (min_q == '0);
    assign key_valid = (bus.data <= 4'd9);

    // Load mode takes priority over counting; enable is irrelevant while loading.
    always_comb begin
        op = OP_HOLD;
        if (!bus.loadn) begin
            op = OP_LOAD;
        end else if (bus.enable) begin
            op = OP_COUNT;
        end
    end

    always_comb begin
        secs_d = secs_q;
        tens_d = tens_q;
        min_d  = min_q;
        case (op)
            OP_LOAD: begin
                if (key_valid) begin
                    min_d  = tens_q;
                    tens_d = secs_q;
                    secs_d = bus.data;
                end
            end
            OP_COUNT: begin
                // Borrow ripples right to left; tens_secs may hold 6..9 after a raw load.
                if (secs_q != '0) begin
                    secs_d = secs_q - 4'd1;
                end else if (tens_q != '0) begin
                    tens_d = tens_q - 4'd1;
                    secs_d = 4'd9;
                end else if (min_q != '0) begin
                    min_d  = min_q - 4'd1;
                    tens_d = 4'd5;
                    secs_d = 4'd9;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!clearn) begin
            secs_q <= '0;
            tens_q <= '0;
            min_q  <= '0;
        end else begin
            secs_q <= secs_d;
            tens_q <= tens_d;
            min_q  <= min_d;
        end
    end

    assign bus.secs       = secs_q;
    assign bus.tens_secs  = tens_q;
    assign bus.minutes    = min_q;
    assign bus.timer_done = all_zero;

endmodule

// File: tb/tb_contador_nivel2_timer.sv
// Scoreboarded bench for the M:SS countdown timer: each applied edge pushes the expected
// {minutes, tens_secs, secs, timer_done} and the owning scenario pops and compares it.
module tb_contador_nivel2_timer;

    logic CLK = 1'b0;
    logic clearn;

    contador_nivel2_timer_if bus ();

    contador_nivel2_timer dut (
        .CLK    (CLK),
        .clearn (clearn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [12:0] sb[$];
    logic [3:0]  m_s = '0, m_t = '0, m_m = '0;

    function automatic logic [12:0] pack(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
        return {m, t, s, (m == 4'd0 && t == 4'd0 && s == 4'd0)};
    endfunction

    function automatic logic [12:0] observed();
        return {bus.minutes, bus.tens_secs, bus.secs, bus.timer_done};
    endfunction

    // Drive one edge's inputs, advance the reference model, queue its expectation, then clock.
    task automatic apply(input logic clr, input logic ld, input logic en, input logic [3:0] d);
        clearn     = clr;
        bus.loadn  = ld;
        bus.enable = en;
        bus.data   = d;
        if (!clr) begin
            m_s = 4'd0; m_t = 4'd0; m_m = 4'd0;
        end else if (!ld) begin
            if (d < 4'd10) begin
                m_m = m_t; m_t = m_s; m_s = d;
            end
        end else if (en) begin
            if (m_m * 60 + m_t * 10 + m_s > 0) begin
                if (m_s > 0) m_s = m_s - 4'd1;
                else if (m_t > 0) begin m_t = m_t - 4'd1; m_s = 4'd9; end
                else begin m_m = m_m - 4'd1; m_t = 4'd5; m_s = 4'd9; end
            end
        end
        sb.push_back(pack(m_m, m_t, m_s));
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp, got;
        apply(1'b0, 1'b1, 1'b0, 4'd0);
        exp = sb.pop_front(); got = observed();
        checks++;
        if (got !== exp || got !== pack(4'd0, 4'd0, 4'd0)) begin
            errors++; $display("FAIL reset: got %h required %h", got, pack(4'd0, 4'd0, 4'd0));
        end
        apply(1'b1, 1'b0, 1'b0, 4'd4);
        exp = sb.pop_front(); got = observed();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_preload: got %h required %h", got, exp); end
        // clearn low between edges must not disturb the digits
        clearn = 1'b0;
        #3;
        got = observed();
        checks++;
        if (got !== pack(4'd0, 4'd0, 4'd4)) begin
            errors++; $display("FAIL reset_no_edge: got %h required %h", got, pack(4'd0, 4'd0, 4'd4));
        end
        @(negedge CLK);
        apply(1'b0, 1'b1, 1'b1, 4'd0);
        exp = sb.pop_front(); got = observed();
        checks++;
        if (got !== exp || got !== pack(4'd0, 4'd0, 4'd0)) begin
            errors++; $display("FAIL reset_edge: got %h required %h", got, pack(4'd0, 4'd0, 4'd0));
        end
    endtask

    task automatic test_load();
        logic [3:0]  keys [4] = '{4'd2, 4'd1, 4'd7, 4'd9};
        logic [12:0] want [4];
        logic [12:0] exp, got;
        want[0] = pack(4'd0, 4'd0, 4'd2);
        want[1] = pack(4'd0, 4'd2, 4'd1);
        want[2] = pack(4'd2, 4'd1, 4'd7);
        want[3] = pack(4'd1, 4'd7, 4'd9);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b1, keys[i]);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp || got !== want[i]) begin
                errors++; $display("FAIL load key %0d: got %h required %h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_countdown();
        logic [12:0] exp, got, want;
        logic        fixed;
        for (int i = 1; i <= 145; i++) begin
            apply(1'b1, 1'b1, 1'b1, 4'd0);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL countdown edge %0d: got %h required %h", i, got, exp);
            end
            fixed = 1'b1;
            case (i)
                9:       want = pack(4'd1, 4'd7, 4'd0);
                10:      want = pack(4'd1, 4'd6, 4'd9);
                79:      want = pack(4'd1, 4'd0, 4'd0);
                80:      want = pack(4'd0, 4'd5, 4'd9);
                139:     want = pack(4'd0, 4'd0, 4'd0);
                145:     want = pack(4'd0, 4'd0, 4'd0);
                default: begin fixed = 1'b0; want = '0; end
            endcase
            if (fixed) begin
                checks++;
                if (got !== want) begin
                    errors++; $display("FAIL countdown milestone %0d: got %h required %h", i, got, want);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0]  keys [3] = '{4'd2, 4'd4, 4'd5};
        logic [12:0] exp, got;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, keys[i]);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL hold_load %0d: got %h required %h", i, got, exp); end
        end
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b1, 4'd0);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL hold_run %0d: got %h required %h", i, got, exp); end
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 1'b0, 4'd7);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp || got !== pack(4'd2, 4'd2, 4'd5)) begin
                errors++; $display("FAIL hold_paused %0d: got %h required %h", i, got, pack(4'd2, 4'd2, 4'd5));
            end
        end
        apply(1'b1, 1'b1, 1'b1, 4'd0);
        exp = sb.pop_front(); got = observed();
        checks++;
        if (got !== exp || got !== pack(4'd2, 4'd2, 4'd4)) begin
            errors++; $display("FAIL hold_resume: got %h required %h", got, pack(4'd2, 4'd2, 4'd4));
        end
    endtask

    task automatic test_invalid_key();
        logic [3:0]  keys [4] = '{4'd12, 4'd10, 4'd15, 4'd5};
        logic [12:0] want [4];
        logic [12:0] exp, got;
        want[0] = pack(4'd2, 4'd2, 4'd4);
        want[1] = pack(4'd2, 4'd2, 4'd4);
        want[2] = pack(4'd2, 4'd2, 4'd4);
        want[3] = pack(4'd2, 4'd4, 4'd5);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, keys[i]);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp || got !== want[i]) begin
                errors++; $display("FAIL invalid_key %0d: got %h required %h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [3:0]  keys [3] = '{4'd0, 4'd5, 4'd2};
        logic [12:0] exp, got;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, keys[i]);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b1, 1'b1, 4'd0);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL midreset_run %0d: got %h required %h", i, got, exp); end
        end
        checks++;
        if (observed() !== pack(4'd0, 4'd4, 4'd5)) begin
            errors++; $display("FAIL midreset_at_045: got %h required %h", observed(), pack(4'd0, 4'd4, 4'd5));
        end
        apply(1'b0, 1'b1, 1'b1, 4'd0);
        exp = sb.pop_front(); got = observed();
        checks++;
        if (got !== exp || got !== pack(4'd0, 4'd0, 4'd0)) begin
            errors++; $display("FAIL midreset_clear: got %h required %h", got, pack(4'd0, 4'd0, 4'd0));
        end
        apply(1'b1, 1'b0, 1'b1, 4'd3);
        apply(1'b1, 1'b0, 1'b1, 4'd0);
        apply(1'b1, 1'b0, 1'b1, 4'd0);
        apply(1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            exp = sb.pop_front();
            if (i == 3) begin
                got = observed();
                checks++;
                if (got !== exp || got !== pack(4'd2, 4'd5, 4'd9)) begin
                    errors++; $display("FAIL midreset_reload: got %h required %h", got, pack(4'd2, 4'd5, 4'd9));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp, got;
        logic        clr, ld, en;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b1, 4'd0);
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL zero_load %0d: got %h required %h", i, got, exp); end
        end
        checks++;
        if (bus.timer_done !== 1'b1) begin
            errors++; $display("FAIL zero_load_done: got %b required 1", bus.timer_done);
        end
        for (int i = 0; i < 300; i++) begin
            clr = ($urandom_range(0, 31) != 0);
            ld  = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 4) != 0);
            apply(clr, ld, en, 4'($urandom_range(0, 15)));
            exp = sb.pop_front(); got = observed();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random op %0d: got %h required %h", i, got, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clearn     = 1'b1;
        bus.loadn  = 1'b1;
        bus.enable = 1'b0;
        bus.data   = '0;
        @(negedge CLK);
        test_reset();
        test_load();
        test_countdown();
        test_hold();
        test_invalid_key();
        test_reset_mid_count();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
